// File: rtl/clock_gen_pkg.sv
// Shared definitions for the generated-clock bank: sequencer states and
// the role assigned to each channel index.
package clock_gen_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } seq_state_e;

    localparam int CH_IMEM = 0;
    localparam int CH_DMEM = 1;
    localparam int CH_PROC = 2;
    localparam int CH_REGF = 3;

endpackage

// File: rtl/clk_div_channel.sv
// One generated clock: half-period counter, phase, shadow/active settings
// and the output flop. New settings take effect only at a 1->0 phase boundary.
module clk_div_channel #(
    parameter int               DIV_W   = 8,
    parameter logic [DIV_W-1:0] DEF_HP  = '0,
    parameter logic             DEF_INV = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             wr_en_i,
    input  logic [DIV_W-1:0] wr_hp_i,
    input  logic             wr_inv_i,
    output logic             clk_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] hp_q, hp_d;
    logic [DIV_W-1:0] sh_hp_q, sh_hp_d;
    logic             phase_q, phase_d;
    logic             inv_q, inv_d;
    logic             sh_inv_q, sh_inv_d;
    logic             run_q, run_d;
    logic             out_q, out_d;
    logic             at_hp_s;

    // Next-state logic for shadow settings, divider and output value
    always_comb begin
        at_hp_s = (cnt_q == hp_q);

        if (wr_en_i) begin
            sh_hp_d  = wr_hp_i;
            sh_inv_d = wr_inv_i;
        end else begin
            sh_hp_d  = sh_hp_q;
            sh_inv_d = sh_inv_q;
        end

        // run_q marks the first enabled edge, which only presents inv
        if (!en_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
            run_d   = 1'b0;
            hp_d    = sh_hp_q;
            inv_d   = sh_inv_q;
            out_d   = 1'b0;
        end else if (!run_q) begin
            cnt_d   = '0;
            phase_d = 1'b0;
            run_d   = 1'b1;
            hp_d    = hp_q;
            inv_d   = inv_q;
            out_d   = inv_q;
        end else if (at_hp_s) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
            run_d   = 1'b1;
            hp_d    = phase_q ? sh_hp_q  : hp_q;
            inv_d   = phase_q ? sh_inv_q : inv_q;
            out_d   = (~phase_q) ^ inv_d;
        end else begin
            cnt_d   = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
            phase_d = phase_q;
            run_d   = 1'b1;
            hp_d    = hp_q;
            inv_d   = inv_q;
            out_d   = phase_q ^ inv_q;
        end
    end

    // Channel state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            run_q    <= 1'b0;
            hp_q     <= DEF_HP;
            inv_q    <= DEF_INV;
            sh_hp_q  <= DEF_HP;
            sh_inv_q <= DEF_INV;
            out_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            run_q    <= run_d;
            hp_q     <= hp_d;
            inv_q    <= inv_d;
            sh_hp_q  <= sh_hp_d;
            sh_inv_q <= sh_inv_d;
            out_q    <= out_d;
        end
    end

    assign clk_o = out_q;

endmodule

// File: rtl/clock_gen_bank.sv
// Generated clock bank: NUM_CH divided clocks with a power-up sequencer that
// enables channels one after another and reports ready when all run.
module clock_gen_bank
    import clock_gen_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int DIV_W       = 8,
    parameter  int DEF_HP      = 0,
    parameter  int DEF_INV     = 0,
    parameter  int START_DLY   = 16,
    parameter  int RELEASE_GAP = 4,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_hp,
    input  logic              cfg_inv,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] ch_en,
    output logic              ready
);

    localparam int DLY_MAX = (START_DLY > RELEASE_GAP) ? START_DLY : RELEASE_GAP;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);

    seq_state_e        state_q;
    logic [DLY_W-1:0]  dly_q;
    logic [CH_W-1:0]   idx_q;
    logic [NUM_CH-1:0] ch_en_q;
    logic              ready_q;
    logic [NUM_CH-1:0] wr_vec_s;

    // Decode the write strobe; indices with no channel match nothing
    always_comb begin
        wr_vec_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                wr_vec_s[i] = 1'b1;
            end else begin
                wr_vec_s[i] = 1'b0;
            end
        end
    end

    // Power-up sequencer: start delay, staggered enables, then RUN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dly_q   <= '0;
            idx_q   <= '0;
            ch_en_q <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dly_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (dly_q == DLY_W'(START_DLY - 1)) begin
                        dly_q      <= '0;
                        ch_en_q[0] <= 1'b1;
                        if (NUM_CH == 1) begin
                            state_q <= RUN;
                            ready_q <= 1'b1;
                        end else begin
                            idx_q   <= CH_W'(1);
                            state_q <= RELEASE;
                        end
                    end else begin
                        dly_q <= dly_q + DLY_W'(1);
                    end
                end
                RELEASE: begin
                    if (dly_q == DLY_W'(RELEASE_GAP - 1)) begin
                        dly_q          <= '0;
                        ch_en_q[idx_q] <= 1'b1;
                        if (idx_q == CH_W'(NUM_CH - 1)) begin
                            state_q <= RUN;
                            ready_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + CH_W'(1);
                        end
                    end else begin
                        dly_q <= dly_q + DLY_W'(1);
                    end
                end
                RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_channel #(
            .DIV_W   (DIV_W),
            .DEF_HP  (DIV_W'(DEF_HP)),
            .DEF_INV (DEF_INV != 0)
        ) u_ch (
            .clk_i    (clock),
            .rst_ni   (reset),
            .en_i     (ch_en_q[g]),
            .wr_en_i  (wr_vec_s[g]),
            .wr_hp_i  (cfg_hp),
            .wr_inv_i (cfg_inv),
            .clk_o    (clk_out[g])
        );
    end

    assign ch_en = ch_en_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_clock_gen_bank.sv
// Directed bench for clock_gen_bank: power-up sequencing, glitch-free
// reconfiguration, ignored out-of-range writes and mid-sequence reset.
module tb_clock_gen_bank;
    import clock_gen_pkg::*;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       cfg_we  = 1'b0;
    logic [1:0] cfg_ch  = 2'd0;
    logic [7:0] cfg_hp  = 8'd0;
    logic       cfg_inv = 1'b0;
    logic [3:0] clk_out;
    logic [3:0] ch_en;
    logic       ready;

    logic       s_cfg_we  = 1'b0;
    logic [1:0] s_cfg_ch  = 2'd0;
    logic [7:0] s_cfg_hp  = 8'd0;
    logic       s_cfg_inv = 1'b0;
    logic [2:0] s_clk_out;
    logic [2:0] s_ch_en;
    logic       s_ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    clock_gen_bank u_dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_hp(cfg_hp), .cfg_inv(cfg_inv), .clk_out(clk_out), .ch_en(ch_en), .ready(ready)
    );

    clock_gen_bank #(.NUM_CH(3)) u_small (
        .clock(clock), .reset(reset), .cfg_we(s_cfg_we), .cfg_ch(s_cfg_ch),
        .cfg_hp(s_cfg_hp), .cfg_inv(s_cfg_inv), .clk_out(s_clk_out), .ch_en(s_ch_en), .ready(s_ready)
    );

    function automatic logic samp(input bit sel, input int ch);
        return sel ? s_clk_out[ch] : clk_out[ch];
    endfunction

    task automatic wait_level(input bit sel, input int ch, input logic val);
        bit hit;
        hit = 1'b0;
        for (int j = 0; j < 600 && !hit; j++) begin
            if (samp(sel, ch) === val) hit = 1'b1;
            else @(negedge clock);
        end
        if (!hit) begin
            n_checks++;
            $display("FAIL wait_level dut%0d ch%0d: level %b never seen, required within 600 cycles", sel, ch, val);
        end
    endtask

    task automatic capture(input bit sel, input int ch, input int n, output logic [31:0] bits);
        bits = '0;
        for (int j = 0; j < n; j++) begin
            if (j > 0) @(negedge clock);
            bits = {bits[30:0], samp(sel, ch)};
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [7:0] hp, input logic inv);
        cfg_we = 1'b1; cfg_ch = ch; cfg_hp = hp; cfg_inv = inv;
        @(negedge clock);
        cfg_we = 1'b0;
    endtask

    // Called right after reset is released at a falling edge; k counts rising edges
    task automatic run_sequence(input bit wr3);
        logic [3:0] exp_en;
        logic [2:0] exp_sen;
        logic       e0, e3, ph;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clock);
            exp_en  = {(k >= 29), (k >= 25), (k >= 21), (k >= 17)};
            exp_sen = {(k >= 25), (k >= 21), (k >= 17)};
            e0 = (k >= 19) && (k % 2 == 1);
            ph = (k >= 31) && ((k - 31) % 2 == 0);
            e3 = (k >= 30) ? (ph ^ wr3) : 1'b0;
            n_checks++;
            if (ch_en !== exp_en) $display("FAIL seq_ch_en k=%0d: got %b expected %b", k, ch_en, exp_en);
            else n_pass++;
            n_checks++;
            if (ready !== (k >= 29)) $display("FAIL seq_ready k=%0d: got %b expected %b", k, ready, (k >= 29));
            else n_pass++;
            n_checks++;
            if (s_ch_en !== exp_sen) $display("FAIL seq_small_ch_en k=%0d: got %b expected %b", k, s_ch_en, exp_sen);
            else n_pass++;
            n_checks++;
            if (s_ready !== (k >= 25)) $display("FAIL seq_small_ready k=%0d: got %b expected %b", k, s_ready, (k >= 25));
            else n_pass++;
            n_checks++;
            if (clk_out[CH_IMEM] !== e0) $display("FAIL seq_clk0 k=%0d: got %b expected %b", k, clk_out[CH_IMEM], e0);
            else n_pass++;
            n_checks++;
            if (clk_out[CH_REGF] !== e3) $display("FAIL seq_clk3 k=%0d: got %b expected %b", k, clk_out[CH_REGF], e3);
            else n_pass++;
            if (wr3 && k == 10) begin
                cfg_we = 1'b1; cfg_ch = 2'd3; cfg_hp = 8'd0; cfg_inv = 1'b1;
            end
            if (k == 11) cfg_we = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({clk_out, ch_en, ready, s_clk_out, s_ch_en, s_ready} !== 16'h0000)
            $display("FAIL reset_outputs: got %b/%b/%b expected all zero", clk_out, ch_en, ready);
        else n_pass++;
        reset = 1'b1;
        run_sequence(1'b0);
    endtask

    task automatic test_cfg_hp();
        logic [31:0] bits;
        wait_level(1'b0, CH_PROC, 1'b0);
        cfg_write(2'd2, 8'd3, 1'b0);
        capture(1'b0, CH_PROC, 13, bits);
        n_checks++;
        if (bits !== 32'b1000011110000) $display("FAIL cfg_hp_ch2: got %b expected %b", bits[12:0], 13'b1000011110000);
        else n_pass++;
    endtask

    task automatic test_cfg_inv();
        logic [31:0] bits;
        wait_level(1'b0, CH_DMEM, 1'b0);
        cfg_write(2'd1, 8'd2, 1'b1);
        capture(1'b0, CH_DMEM, 13, bits);
        n_checks++;
        if (bits !== 32'b1111000111000) $display("FAIL cfg_inv_ch1: got %b expected %b", bits[12:0], 13'b1111000111000);
        else n_pass++;
    endtask

    task automatic test_last_write_wins();
        logic [31:0] bits;
        cfg_write(2'd0, 8'd2, 1'b0);
        repeat (12) @(negedge clock);
        wait_level(1'b0, CH_IMEM, 1'b0);
        wait_level(1'b0, CH_IMEM, 1'b1);
        cfg_write(2'd0, 8'd5, 1'b0);
        cfg_write(2'd0, 8'd1, 1'b0);
        capture(1'b0, CH_IMEM, 11, bits);
        n_checks++;
        if (bits !== 32'b10011001100) $display("FAIL last_write_ch0: got %b expected %b", bits[10:0], 11'b10011001100);
        else n_pass++;
    endtask

    task automatic test_same_edge();
        logic [31:0] bits;
        wait_level(1'b0, CH_REGF, 1'b1);
        cfg_write(2'd3, 8'd1, 1'b0);
        capture(1'b0, CH_REGF, 8, bits);
        n_checks++;
        if (bits !== 32'b01001100) $display("FAIL same_edge_ch3: got %b expected %b", bits[7:0], 8'b01001100);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] bits;
        s_cfg_we = 1'b1; s_cfg_ch = 2'd3; s_cfg_hp = 8'd7; s_cfg_inv = 1'b1;
        @(negedge clock);
        s_cfg_we = 1'b0;
        repeat (4) @(negedge clock);
        for (int c = 0; c < 3; c++) begin
            wait_level(1'b1, c, 1'b0);
            capture(1'b1, c, 8, bits);
            n_checks++;
            if (bits !== 32'b01010101) $display("FAIL out_of_range ch%0d: got %b expected %b", c, bits[7:0], 8'b01010101);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] bits;
        @(negedge clock); reset = 1'b0;
        @(negedge clock); reset = 1'b1;
        repeat (23) @(negedge clock);
        n_checks++;
        if ({ch_en, clk_out, ready} !== 9'b0011_0011_0) $display("FAIL midop_pre: got en=%b clk=%b rdy=%b expected en=0011 clk=0011 rdy=0", ch_en, clk_out, ready);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({ch_en, clk_out, ready} !== 9'b0) $display("FAIL midop_async: got en=%b clk=%b rdy=%b expected all zero", ch_en, clk_out, ready);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if ({ch_en, clk_out, ready} !== 9'b0) $display("FAIL midop_hold: got en=%b clk=%b rdy=%b expected all zero", ch_en, clk_out, ready);
        else n_pass++;
        reset = 1'b1;
        run_sequence(1'b1);
        for (int c = 0; c < 3; c++) begin
            wait_level(1'b0, c, 1'b0);
            capture(1'b0, c, 8, bits);
            n_checks++;
            if (bits !== 32'b01010101) $display("FAIL midop_default ch%0d: got %b expected %b", c, bits[7:0], 8'b01010101);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_cfg_hp();
        test_cfg_inv();
        test_last_write_wins();
        test_same_edge();
        test_out_of_range();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
